// File: rtl/adc_sample_averager.sv
// Averages 2^AVG_SEL SAR ADC conversions per window and queues each truncated
// mean in a small result FIFO with a valid/ready consumer interface.
module adc_sample_averager #(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       EOC_N,
    input  logic [7:0] Q,
    input  logic [2:0] AVG_SEL,
    input  logic       CLR,
    output logic [7:0] DOUT,
    output logic       DOUT_VALID,
    input  logic       DOUT_READY,
    output logic       BUSY,
    output logic       OVERFLOW
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam logic [PtrW:0] FullCnt = (PtrW + 1)'(FIFO_DEPTH);

    typedef enum logic [0:0] {StIdle, StAccum} state_e;

    state_e          state_q;
    logic            eoc_prev_q;
    logic [14:0]     acc_q;
    logic [7:0]      cnt_q;
    logic [2:0]      sel_q;

    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q;
    logic [PtrW-1:0] rd_ptr_q;
    logic [PtrW:0]   count_q;
    logic            overflow_q;

    logic            capture;
    logic [14:0]     acc_sum;
    logic [7:0]      cnt_inc;
    logic [7:0]      win_len;
    logic            push;
    logic [7:0]      push_data;
    logic            fifo_full;
    logic            pop;
    logic            push_ok;
    logic            push_drop;

    // Edge detect on EOC_N; keeps tracking through CLR so a held-low EOC_N
    // is not re-captured once the flush ends.
    always_ff @(posedge CLK) begin
        if (RST) begin
            eoc_prev_q <= 1'b1;
        end else begin
            eoc_prev_q <= EOC_N;
        end
    end

    // Capture decode and result generation for the window-closing sample.
    always_comb begin
        capture   = eoc_prev_q & ~EOC_N;
        acc_sum   = acc_q + {7'd0, Q};
        cnt_inc   = cnt_q + 8'd1;
        win_len   = 8'd1 << sel_q;
        push      = 1'b0;
        push_data = Q;
        if (capture) begin
            if (state_q == StIdle) begin
                // Single-sample window: the raw sample is the result.
                push      = (AVG_SEL == 3'd0);
                push_data = Q;
            end else if (cnt_inc == win_len) begin
                push      = 1'b1;
                // Full-window sum >> sel_q never exceeds 8 bits.
                push_data = 8'(acc_sum >> sel_q);
            end
        end
    end

    // FIFO handshake decode; a pop frees a slot for a same-cycle push at full.
    always_comb begin
        DOUT_VALID = (count_q != '0);
        fifo_full  = (count_q == FullCnt);
        pop        = DOUT_VALID & DOUT_READY;
        push_ok    = push & (~fifo_full | pop);
        push_drop  = push & fifo_full & ~pop;
        DOUT       = DOUT_VALID ? mem_q[rd_ptr_q] : 8'd0;
        BUSY       = (state_q == StAccum);
        OVERFLOW   = overflow_q;
    end

    // Averaging FSM: window start latches AVG_SEL, later captures accumulate.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= StIdle;
            acc_q   <= 15'd0;
            cnt_q   <= 8'd0;
            sel_q   <= 3'd0;
        end else if (CLR) begin
            state_q <= StIdle;
            acc_q   <= 15'd0;
            cnt_q   <= 8'd0;
        end else if (capture) begin
            unique case (state_q)
                StIdle: begin
                    sel_q   <= AVG_SEL;
                    acc_q   <= {7'd0, Q};
                    cnt_q   <= 8'd1;
                    state_q <= (AVG_SEL == 3'd0) ? StIdle : StAccum;
                end
                StAccum: begin
                    acc_q <= acc_sum;
                    cnt_q <= cnt_inc;
                    if (cnt_inc == win_len) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Result storage; contents need no reset since DOUT is gated by DOUT_VALID.
    always_ff @(posedge CLK) begin
        if (push_ok && !RST && !CLR) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    // FIFO pointers, occupancy and sticky overflow flag.
    always_ff @(posedge CLK) begin
        if (RST || CLR) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            if (push_ok && !pop) begin
                count_q <= count_q + (PtrW + 1)'(1);
            end else if (pop && !push_ok) begin
                count_q <= count_q - (PtrW + 1)'(1);
            end
            if (push_drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_adc_sample_averager.sv
// Directed bench for adc_sample_averager: one task per scenario, inline checks.
module tb_adc_sample_averager;

    logic       CLK;
    logic       RST;
    logic       EOC_N;
    logic [7:0] Q;
    logic [2:0] AVG_SEL;
    logic       CLR;
    logic [7:0] DOUT;
    logic       DOUT_VALID;
    logic       DOUT_READY;
    logic       BUSY;
    logic       OVERFLOW;

    int total = 0;
    int bad   = 0;

    adc_sample_averager #(.FIFO_DEPTH(4)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .EOC_N      (EOC_N),
        .Q          (Q),
        .AVG_SEL    (AVG_SEL),
        .CLR        (CLR),
        .DOUT       (DOUT),
        .DOUT_VALID (DOUT_VALID),
        .DOUT_READY (DOUT_READY),
        .BUSY       (BUSY),
        .OVERFLOW   (OVERFLOW)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Falling EOC_N edge with data q; returns just after the capture edge with EOC_N high again.
    task automatic capture(input logic [7:0] q);
        EOC_N = 1'b0;
        Q     = q;
        tick();
        EOC_N = 1'b1;
        Q     = 8'h00;
    endtask

    task automatic test_reset();
        RST = 1'b1; CLR = 1'b0; EOC_N = 1'b1; Q = 8'h00; AVG_SEL = 3'd0; DOUT_READY = 1'b0;
        tick(); tick();
        RST = 1'b0;
        total++; if (DOUT !== 8'h00) begin bad++; $display("FAIL reset_dout got=%0h want=0", DOUT); end
        total++; if (DOUT_VALID !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b want=0", DOUT_VALID); end
        total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b want=0", BUSY); end
        total++; if (OVERFLOW !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%0b want=0", OVERFLOW); end
        tick();
    endtask

    task automatic test_single();
        logic [7:0] vals [3];
        vals[0] = 8'h12; vals[1] = 8'hFF; vals[2] = 8'h00;
        AVG_SEL = 3'd0; DOUT_READY = 1'b1;
        for (int i = 0; i < 3; i++) begin
            capture(vals[i]);
            total++; if (DOUT_VALID !== 1'b1) begin bad++; $display("FAIL single_valid[%0d] got=%0b want=1", i, DOUT_VALID); end
            total++; if (DOUT !== vals[i]) begin bad++; $display("FAIL single_dout[%0d] got=%0h want=%0h", i, DOUT, vals[i]); end
            total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL single_busy[%0d] got=%0b want=0", i, BUSY); end
            tick();
            total++; if (DOUT_VALID !== 1'b0) begin bad++; $display("FAIL single_popped[%0d] got=%0b want=0", i, DOUT_VALID); end
        end
    endtask

    // Window of 4: 10+11+12+14 = 47, 47>>2 = 11. AVG_SEL changed mid-window must not matter.
    task automatic test_avg4();
        logic [7:0] vals [4];
        vals[0] = 8'd10; vals[1] = 8'd11; vals[2] = 8'd12; vals[3] = 8'd14;
        AVG_SEL = 3'd2; DOUT_READY = 1'b1;
        for (int i = 0; i < 3; i++) begin
            capture(vals[i]);
            if (i == 0) AVG_SEL = 3'd0;
            total++; if (BUSY !== 1'b1) begin bad++; $display("FAIL avg4_busy[%0d] got=%0b want=1", i, BUSY); end
            total++; if (DOUT_VALID !== 1'b0) begin bad++; $display("FAIL avg4_early_valid[%0d] got=%0b want=0", i, DOUT_VALID); end
            tick();
        end
        capture(vals[3]);
        total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL avg4_busy_end got=%0b want=0", BUSY); end
        total++; if (DOUT_VALID !== 1'b1) begin bad++; $display("FAIL avg4_valid got=%0b want=1", DOUT_VALID); end
        total++; if (DOUT !== 8'd11) begin bad++; $display("FAIL avg4_dout got=%0h want=b", DOUT); end
        tick();
        total++; if (DOUT_VALID !== 1'b0) begin bad++; $display("FAIL avg4_single got=%0b want=0", DOUT_VALID); end
    endtask

    // 128 x 0xFF, first sample held low 5 cycles; sum 32640 >> 7 = 255.
    task automatic test_avg128();
        AVG_SEL = 3'd7; DOUT_READY = 1'b0;
        EOC_N = 1'b0; Q = 8'hFF;
        repeat (5) tick();
        EOC_N = 1'b1; Q = 8'h00;
        tick();
        for (int i = 1; i < 127; i++) begin
            capture(8'hFF);
            tick();
        end
        total++; if (BUSY !== 1'b1) begin bad++; $display("FAIL avg128_busy got=%0b want=1", BUSY); end
        total++; if (DOUT_VALID !== 1'b0) begin bad++; $display("FAIL avg128_early got=%0b want=0", DOUT_VALID); end
        capture(8'hFF);
        total++; if (DOUT_VALID !== 1'b1) begin bad++; $display("FAIL avg128_valid got=%0b want=1", DOUT_VALID); end
        total++; if (DOUT !== 8'hFF) begin bad++; $display("FAIL avg128_dout got=%0h want=ff", DOUT); end
        total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL avg128_idle got=%0b want=0", BUSY); end
        DOUT_READY = 1'b1;
        tick();
        total++; if (DOUT_VALID !== 1'b0) begin bad++; $display("FAIL avg128_drain got=%0b want=0", DOUT_VALID); end
    endtask

    task automatic test_overflow();
        AVG_SEL = 3'd0; DOUT_READY = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            capture(8'(i));
            tick();
            if (i == 4) begin
                total++; if (OVERFLOW !== 1'b0) begin bad++; $display("FAIL ovf_at_full got=%0b want=0", OVERFLOW); end
            end
        end
        total++; if (OVERFLOW !== 1'b1) begin bad++; $display("FAIL ovf_set got=%0b want=1", OVERFLOW); end
        total++; if (DOUT !== 8'd1) begin bad++; $display("FAIL ovf_head_stable got=%0h want=1", DOUT); end
        DOUT_READY = 1'b1;
        for (int i = 2; i <= 4; i++) begin
            tick();
            total++; if (DOUT !== 8'(i)) begin bad++; $display("FAIL ovf_drain[%0d] got=%0h want=%0h", i, DOUT, i); end
        end
        tick();
        total++; if (DOUT_VALID !== 1'b0) begin bad++; $display("FAIL ovf_empty got=%0b want=0", DOUT_VALID); end
        total++; if (OVERFLOW !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%0b want=1", OVERFLOW); end
        CLR = 1'b1;
        tick();
        CLR = 1'b0;
        total++; if (OVERFLOW !== 1'b0) begin bad++; $display("FAIL ovf_clr got=%0b want=0", OVERFLOW); end
        // Refill to full, then push and pop in the same cycle.
        DOUT_READY = 1'b0;
        for (int i = 6; i <= 9; i++) begin
            capture(8'(i));
            tick();
        end
        DOUT_READY = 1'b1;
        capture(8'd10);
        total++; if (OVERFLOW !== 1'b0) begin bad++; $display("FAIL pushpop_ovf got=%0b want=0", OVERFLOW); end
        for (int i = 7; i <= 10; i++) begin
            total++; if (DOUT !== 8'(i) || DOUT_VALID !== 1'b1) begin bad++; $display("FAIL pushpop_drain[%0d] got=%0h/%0b want=%0h/1", i, DOUT, DOUT_VALID, i); end
            tick();
        end
        total++; if (DOUT_VALID !== 1'b0) begin bad++; $display("FAIL pushpop_empty got=%0b want=0", DOUT_VALID); end
    endtask

    task automatic test_clr_mid();
        AVG_SEL = 3'd0; DOUT_READY = 1'b0;
        for (int i = 0; i < 5; i++) begin
            capture(8'h55);
            tick();
        end
        AVG_SEL = 3'd3;
        for (int i = 0; i < 5; i++) begin
            capture(8'h20);
            tick();
        end
        total++; if (BUSY !== 1'b1 || OVERFLOW !== 1'b1) begin bad++; $display("FAIL clr_pre got=%0b/%0b want=1/1", BUSY, OVERFLOW); end
        EOC_N = 1'b0; Q = 8'h99; CLR = 1'b1;
        tick();
        CLR = 1'b0; EOC_N = 1'b1; Q = 8'h00;
        total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL clr_busy got=%0b want=0", BUSY); end
        total++; if (DOUT_VALID !== 1'b0) begin bad++; $display("FAIL clr_valid got=%0b want=0", DOUT_VALID); end
        total++; if (OVERFLOW !== 1'b0) begin bad++; $display("FAIL clr_ovf got=%0b want=0", OVERFLOW); end
        tick();
        DOUT_READY = 1'b1;
        for (int i = 0; i < 7; i++) begin
            capture(8'h40);
            tick();
        end
        total++; if (BUSY !== 1'b1 || DOUT_VALID !== 1'b0) begin bad++; $display("FAIL clr_window7 got=%0b/%0b want=1/0", BUSY, DOUT_VALID); end
        capture(8'h40);
        total++; if (DOUT_VALID !== 1'b1 || DOUT !== 8'h40) begin bad++; $display("FAIL clr_result got=%0b/%0h want=1/40", DOUT_VALID, DOUT); end
        tick();
    endtask

    task automatic test_rst_mid();
        AVG_SEL = 3'd2; DOUT_READY = 1'b1;
        for (int i = 0; i < 2; i++) begin
            capture(8'h80);
            tick();
        end
        total++; if (BUSY !== 1'b1) begin bad++; $display("FAIL rst_pre_busy got=%0b want=1", BUSY); end
        EOC_N = 1'b0; Q = 8'hEE; RST = 1'b1;
        tick();
        RST = 1'b0; EOC_N = 1'b1; Q = 8'h00;
        total++; if (BUSY !== 1'b0 || DOUT_VALID !== 1'b0) begin bad++; $display("FAIL rst_mid got=%0b/%0b want=0/0", BUSY, DOUT_VALID); end
        tick();
        for (int i = 0; i < 3; i++) begin
            capture(8'h30);
            tick();
        end
        total++; if (BUSY !== 1'b1 || DOUT_VALID !== 1'b0) begin bad++; $display("FAIL rst_window3 got=%0b/%0b want=1/0", BUSY, DOUT_VALID); end
        capture(8'h30);
        total++; if (DOUT_VALID !== 1'b1 || DOUT !== 8'h30) begin bad++; $display("FAIL rst_result got=%0b/%0h want=1/30", DOUT_VALID, DOUT); end
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_avg4();
        test_avg128();
        test_overflow();
        test_clr_mid();
        test_rst_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule

// File: doc/adc_sample_averager.md
ADC_SAMPLE_AVERAGER -- requirements
Module: adc_sample_averager

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, result FIFO entries (power of two, 2..16).
REQ-002 SHALL have ports:
  - CLK  in  1  sole clock.
  - RST  in  1  reset; one clock, reset is synchronous and active-high.
  - EOC_N  in  1  from the SAR ADC top; low = Q valid; may stay low multiple cycles.
  - Q  in  8  ADC conversion data.
  - AVG_SEL  in  3  log2 of samples per average (0..7 -> 1..128).
  - CLR  in  1  synchronous abort/flush.
  - DOUT  out  8  averaged result, FIFO head.
  - DOUT_VALID  out  1  FIFO non-empty.
  - DOUT_READY  in  1  consumer accepts DOUT.
  - BUSY  out  1  averaging window in progress.
  - OVERFLOW  out  1  sticky, result dropped on full FIFO.

Function
REQ-003 SHALL register EOC_N into eoc_prev each cycle; eoc_prev reset value 1.
REQ-004 SHALL define capture = (eoc_prev==1 && EOC_N==0); exactly one capture per EOC_N falling edge, regardless of low duration.
REQ-005 SHALL sample Q in the capture cycle; Q is ignored in all other cycles.
REQ-006 SHALL implement FSM states IDLE and ACCUM; BUSY = (state==ACCUM).
REQ-007 IDLE + capture: SHALL latch AVG_SEL into sel_q, load acc=Q, cnt=1.
  - if 2^sel_q==1, SHALL push Q to FIFO and stay IDLE;
  - else SHALL go to ACCUM.
REQ-008 ACCUM + capture: SHALL set acc=acc+Q and cnt=cnt+1.
  - when cnt+1 == 2^sel_q, SHALL push (acc+Q)>>sel_q and return to IDLE.
REQ-009 acc SHALL be 15 bits (8+7); no accumulator overflow is possible.
  - Averaging SHALL truncate, no rounding.
  - cnt SHALL be 8 bits.
REQ-010 AVG_SEL changes SHALL take effect only at the next window start; the in-flight window uses sel_q.
REQ-011 FIFO push SHALL occur at the clock edge ending the final-capture cycle; DOUT_VALID SHALL be high from that edge.
  - Latency: 1 cycle from the first cycle EOC_N is low (final sample) to DOUT_VALID.
REQ-012 Pop SHALL occur when DOUT_VALID && DOUT_READY.
  - DOUT SHALL hold stable while DOUT_VALID && !DOUT_READY.
REQ-013 FIFO SHALL be first-in first-out; pointers SHALL wrap modulo FIFO_DEPTH; occupancy count width SHALL be log2(FIFO_DEPTH)+1.
REQ-014 Push when full without a same-cycle pop: SHALL drop the result, leave FIFO contents unchanged, and set OVERFLOW.
REQ-015 Push and pop in the same cycle when full: SHALL accept both; occupancy unchanged; no OVERFLOW.
REQ-016 Push and pop in the same cycle when empty is not possible; DOUT_VALID is registered, so there is no bypass.
REQ-017 CLR SHALL take priority over capture, push and pop in the same cycle.
  - CLR SHALL force: IDLE, acc=0, cnt=0, FIFO empty, OVERFLOW=0.
  - eoc_prev SHALL still update normally.
REQ-018 OVERFLOW SHALL clear only on RST or CLR.

Reset
REQ-019 RST SHALL take priority over CLR; it is sampled at the CLK rising edge.
REQ-020 RST SHALL set: state=IDLE, acc=0, cnt=0, sel_q=0, eoc_prev=1, FIFO pointers=0.
  - Outputs after RST: DOUT=0, DOUT_VALID=0, BUSY=0, OVERFLOW=0.
REQ-021 RST asserted mid-window SHALL discard the partial accumulation; the next capture after release starts a new window.

Verification
REQ-022 AVG_SEL=0, DOUT_READY=1; EOC_N pulses with Q=0x12, 0xFF, 0x00:
  - DOUT_VALID high 1 cycle after each falling edge;
  - DOUT = 0x12, 0xFF, 0x00 in order.
REQ-023 AVG_SEL=2; Q=10, 11, 12, 14 on four edges:
  - BUSY high from the first capture until the fourth;
  - single DOUT=11 (47>>2, truncated).
REQ-024 AVG_SEL=7; 128 samples of 0xFF:
  - DOUT=0xFF, no wrap error;
  - EOC_N held low 5 cycles counts as one sample.
REQ-025 FIFO_DEPTH=4, AVG_SEL=0, DOUT_READY=0; 5 edges, Q=1..5:
  - FIFO holds 1..4, OVERFLOW=1;
  - raise DOUT_READY: DOUT = 1, 2, 3, 4, then DOUT_VALID=0.
  - Repeat at full with DOUT_READY=1 and push in the same cycle: no OVERFLOW.
REQ-026 AVG_SEL=3, 5 samples in; CLR (or RST) pulse asserted in the same cycle as an EOC_N edge:
  - BUSY=0, FIFO empty, OVERFLOW=0, that sample ignored;
  - next 8 samples of 0x40 yield DOUT=0x40.
